// File: rtl/ahb_slave_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_slave_arbiter
// Burst-aware AHB bus arbiter. It grants one of MASTER_NUM requesters at a
// time, using fixed priority (ARB_MODE=0) or round-robin (ARB_MODE=1). The
// grant is held for a whole burst. The grant never moves while hready is low.
//
// Ports
//   hclk          : clock, rising edge
//   hreset_n      : asynchronous active-low reset
//   hreq          : per-master bus request
//   htrans        : owner transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hburst        : owner burst type (SINGLE..INCR16)
//   hready        : slave ready, 1 = current beat completes
//   hgrant        : registered one-hot (or zero) grant vector
//   hmaster       : registered index of the granted master, 0 when none
//   hsel          : registered OR of hgrant
//   burst_active  : registered, high while the owner is mid-burst
// ---------------------------------------------------------------------------
module ahb_slave_arbiter #(
  parameter int unsigned MASTER_NUM = 4,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned MW         = $clog2(MASTER_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [MASTER_NUM-1:0] hreq,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [MW-1:0]         hmaster,
  output logic                  hsel,
  output logic                  burst_active
);

  localparam int unsigned IW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = 5;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Burst length in beats; 0 encodes the undefined-length INCR burst.
  function automatic logic [LW-1:0] burst_len(input logic [2:0] hb);
    case (hb)
      3'd0:       burst_len = LW'(1);
      3'd1:       burst_len = LW'(0);
      3'd2, 3'd3: burst_len = LW'(4);
      3'd4, 3'd5: burst_len = LW'(8);
      default:    burst_len = LW'(16);
    endcase
  endfunction

  state_t                  state_q;
  logic [IW-1:0]           owner_q;
  logic [IW-1:0]           ptr_q;
  logic [CW-1:0]           cnt_q;
  logic [LW-1:0]           len_q;
  logic [MASTER_NUM-1:0]   hgrant_q;
  logic [MW-1:0]           hmaster_q;
  logic                    hsel_q;
  logic                    burst_q;

  logic                    win_found;
  logic [IW-1:0]           win_idx;
  logic [IW-1:0]           ptr_d;
  int unsigned             base;
  int unsigned             cand;
  logic                    beat_done;
  logic                    is_nonseq;
  logic                    owner_req;
  logic [LW-1:0]           len_d;
  logic [CW-1:0]           eff_cnt;
  logic [CW-1:0]           cnt_d;
  logic                    last_beat;
  logic                    arb;

  // Winner search: from index 0 (fixed) or from the rotating pointer (RR).
  // Because the pointer sits at owner+1, the owner is visited last in RR mode.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    base      = (ARB_MODE == 1) ? 32'(ptr_q) : 32'd0;
    for (int unsigned k = 0; k < MASTER_NUM; k++) begin
      cand = (base + k) % MASTER_NUM;
      if (!win_found && hreq[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
    ptr_d = (win_idx == IW'(MASTER_NUM - 1)) ? '0 : win_idx + IW'(1);
  end

  // Beat tracking and arbitration-point detection. A NONSEQ beat starts a
  // fresh burst, so it is measured against its own length from count 0.
  always_comb begin
    beat_done = hready && htrans[1];
    is_nonseq = (htrans == TR_NONSEQ);
    owner_req = hreq[owner_q];
    len_d     = is_nonseq ? burst_len(hburst) : len_q;
    eff_cnt   = is_nonseq ? '0 : cnt_q;
    cnt_d     = eff_cnt + CW'(1);
    last_beat = beat_done && (len_d != '0) &&
                ({1'b0, eff_cnt} == (len_d - LW'(1)));
    case (state_q)
      ST_OWNED: arb = hready && (!owner_req || last_beat);
      ST_BURST: arb = hready && (last_beat || (htrans == TR_IDLE) ||
                                 ((len_q == '0) && !owner_req));
      default:  arb = hready;
    endcase
  end

  // State machine with registered grant outputs.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      len_q     <= LW'(1);
      hgrant_q  <= '0;
      hmaster_q <= '0;
      hsel_q    <= 1'b0;
      burst_q   <= 1'b0;
    end else if (arb) begin
      cnt_q   <= '0;
      burst_q <= 1'b0;
      if ((state_q != ST_IDLE) && beat_done && is_nonseq) begin
        len_q <= len_d;
      end
      if (win_found) begin
        state_q           <= ST_OWNED;
        owner_q           <= win_idx;
        ptr_q             <= ptr_d;
        hgrant_q          <= '0;
        hgrant_q[win_idx] <= 1'b1;
        hmaster_q         <= MW'(win_idx);
        hsel_q            <= 1'b1;
      end else begin
        state_q   <= ST_IDLE;
        hgrant_q  <= '0;
        hmaster_q <= '0;
        hsel_q    <= 1'b0;
      end
    end else if ((state_q != ST_IDLE) && beat_done) begin
      state_q <= ST_BURST;
      burst_q <= 1'b1;
      cnt_q   <= cnt_d;
      if (is_nonseq) begin
        len_q <= len_d;
      end
    end
  end

  assign hgrant       = hgrant_q;
  assign hmaster      = hmaster_q;
  assign hsel         = hsel_q;
  assign burst_active = burst_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_arbiter
// Directed bench for ahb_slave_arbiter. One fixed-priority and one
// round-robin instance share the same inputs.
// ---------------------------------------------------------------------------
module tb_ahb_slave_arbiter;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_WRAP8 = 3'd4,
                         B_INCR8 = 3'd5, B_INCR16 = 3'd7;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [3:0] hreq;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;

  logic [3:0] fx_gnt, rr_gnt;
  logic [1:0] fx_mst, rr_mst;
  logic       fx_sel, rr_sel, fx_bst, rr_bst;

  int n_cmp = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  ahb_slave_arbiter #(.MASTER_NUM(4), .ARB_MODE(0)) dut_fx (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .htrans(htrans),
    .hburst(hburst), .hready(hready), .hgrant(fx_gnt), .hmaster(fx_mst),
    .hsel(fx_sel), .burst_active(fx_bst)
  );

  ahb_slave_arbiter #(.MASTER_NUM(4), .ARB_MODE(1)) dut_rr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .htrans(htrans),
    .hburst(hburst), .hready(hready), .hgrant(rr_gnt), .hmaster(rr_mst),
    .hsel(rr_sel), .burst_active(rr_bst)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fx(input string tag, input logic [3:0] g, input logic [1:0] m,
                        input logic s, input logic b);
    check({tag, ".hgrant"}, 32'(fx_gnt), 32'(g));
    check({tag, ".hmaster"}, 32'(fx_mst), 32'(m));
    check({tag, ".hsel"}, 32'(fx_sel), 32'(s));
    check({tag, ".burst_active"}, 32'(fx_bst), 32'(b));
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go_idle();
    htrans = T_IDLE;
    hreq   = 4'b0000;
    hready = 1'b1;
    ticks(2);
  endtask

  // Grant vector must be one-hot or zero at all times.
  always @(negedge hclk) begin
    check("onehot0_fx", 32'($onehot0(fx_gnt)), 32'd1);
    check("onehot0_rr", 32'($onehot0(rr_gnt)), 32'd1);
  end

  initial begin
    hreset_n = 1'b0;
    hreq     = 4'b0000;
    htrans   = T_IDLE;
    hburst   = B_SINGLE;
    hready   = 1'b1;
    #3;
    chk_fx("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge hclk);
    hreset_n = 1'b1;

    // No requests: remain idle with zero grant.
    tick();
    chk_fx("no_req", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Fixed priority picks the lowest requester, one edge of latency.
    hreq = 4'b1010;
    tick();
    chk_fx("fixed_1010", 4'b0010, 2'd1, 1'b1, 1'b0);
    go_idle();
    chk_fx("idle_after_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

    // INCR4 by master 1 while master 0 also requests.
    hreq = 4'b0010;
    tick();
    hreq = 4'b0011; htrans = T_NSEQ; hburst = B_INCR4;
    tick();
    chk_fx("incr4_b1", 4'b0010, 2'd1, 1'b1, 1'b1);
    htrans = T_SEQ;
    ticks(2);
    chk_fx("incr4_b3", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick();
    chk_fx("incr4_release", 4'b0001, 2'd0, 1'b1, 1'b0);
    go_idle();

    // Hready low in idle defers the grant.
    hready = 1'b0; hreq = 4'b0010;
    tick();
    chk_fx("idle_wait", 4'b0000, 2'd0, 1'b0, 1'b0);
    hready = 1'b1;
    tick();
    chk_fx("idle_wait_done", 4'b0010, 2'd1, 1'b1, 1'b0);
    go_idle();

    // INCR8 with one BUSY and three wait cycles on beat 8.
    hreq = 4'b0010;
    tick();
    hreq = 4'b0011; htrans = T_NSEQ; hburst = B_INCR8;
    tick();
    htrans = T_SEQ;
    ticks(2);
    htrans = T_BUSY;
    tick();
    chk_fx("incr8_busy", 4'b0010, 2'd1, 1'b1, 1'b1);
    htrans = T_SEQ;
    ticks(4);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_fx("incr8_wait", 4'b0010, 2'd1, 1'b1, 1'b1);
    end
    hready = 1'b1;
    tick();
    chk_fx("incr8_release", 4'b0001, 2'd0, 1'b1, 1'b0);
    go_idle();

    // INCR16 cut short by IDLE at beat 5.
    hreq = 4'b0100;
    tick();
    chk_fx("incr16e_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    hreq = 4'b0101; htrans = T_NSEQ; hburst = B_INCR16;
    tick();
    htrans = T_SEQ;
    ticks(3);
    chk_fx("incr16e_b4", 4'b0100, 2'd2, 1'b1, 1'b1);
    htrans = T_IDLE;
    tick();
    chk_fx("incr16e_term", 4'b0001, 2'd0, 1'b1, 1'b0);
    go_idle();

    // Full INCR16: count reaches 15 without early release.
    hreq = 4'b0010;
    tick();
    hreq = 4'b0011; htrans = T_NSEQ; hburst = B_INCR16;
    tick();
    htrans = T_SEQ;
    ticks(14);
    chk_fx("incr16_b15", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick();
    chk_fx("incr16_release", 4'b0001, 2'd0, 1'b1, 1'b0);
    go_idle();

    // NONSEQ mid-burst restarts the count.
    hreq = 4'b0010;
    tick();
    hreq = 4'b0011; htrans = T_NSEQ; hburst = B_INCR4;
    tick();
    htrans = T_SEQ;
    ticks(2);
    htrans = T_NSEQ;
    tick();
    chk_fx("restart_nseq", 4'b0010, 2'd1, 1'b1, 1'b1);
    htrans = T_SEQ;
    ticks(2);
    chk_fx("restart_b3", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick();
    chk_fx("restart_release", 4'b0001, 2'd0, 1'b1, 1'b0);
    go_idle();

    // Asynchronous reset mid-WRAP8, then re-arbitration on the first edge.
    hreq = 4'b0001;
    tick();
    htrans = T_NSEQ; hburst = B_WRAP8;
    tick();
    htrans = T_SEQ;
    ticks(2);
    #2;
    hreset_n = 1'b0;
    #1;
    chk_fx("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    hreq = 4'b0100; htrans = T_IDLE; hburst = B_SINGLE;
    @(negedge hclk);
    hreset_n = 1'b1;
    tick();
    chk_fx("post_reset", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Round-robin rotation with SINGLE transfers, all masters requesting.
    hreset_n = 1'b0;
    hreq = 4'b1111; htrans = T_NSEQ; hburst = B_SINGLE; hready = 1'b1;
    @(negedge hclk);
    hreset_n = 1'b1;
    tick();
    check("rr0.hgrant", 32'(rr_gnt), 32'h1);
    check("rr0.hmaster", 32'(rr_mst), 32'd0);
    tick();
    check("rr1.hgrant", 32'(rr_gnt), 32'h2);
    check("rr1.hmaster", 32'(rr_mst), 32'd1);
    check("fx_regrant", 32'(fx_gnt), 32'h1);
    tick();
    check("rr2.hgrant", 32'(rr_gnt), 32'h4);
    tick();
    check("rr3.hgrant", 32'(rr_gnt), 32'h8);
    check("rr3.hmaster", 32'(rr_mst), 32'd3);
    tick();
    check("rr4.hgrant", 32'(rr_gnt), 32'h1);
    check("rr4.hsel", 32'(rr_sel), 32'd1);
    check("rr4.burst", 32'(rr_bst), 32'd0);
    hreq = 4'b0001;
    tick();
    check("rr_alone.hgrant", 32'(rr_gnt), 32'h1);
    hreq = 4'b0011;
    tick();
    check("rr_yield.hgrant", 32'(rr_gnt), 32'h2);
    check("fx_keep.hgrant", 32'(fx_gnt), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_slave_arbiter.md
AHB_SLAVE_ARBITER -- requirements
Module: ahb_slave_arbiter

Interface
- REQ-001 SHALL have parameter MASTER_NUM, default 4, range 2..16: number of requesting masters.
- REQ-002 SHALL have parameter ARB_MODE, default 0: 0 = fixed priority (index 0 highest), 1 = round-robin.
- REQ-003 SHALL have parameter MW, default $clog2(MASTER_NUM): width of hmaster.
- REQ-004 SHALL have port hclk, input, 1: clock, rising edge.
- REQ-005 SHALL have port hreset_n, input, 1: reset, asynchronous, active-low.
- REQ-006 SHALL have port hreq, input, MASTER_NUM: per-master bus request.
- REQ-007 SHALL have port htrans, input, 2: owner transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- REQ-008 SHALL have port hburst, input, 3: owner burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- REQ-009 SHALL have port hready, input, 1: slave ready; 1 = current beat completes.
- REQ-010 SHALL have port hgrant, output, MASTER_NUM: one-hot or zero grant vector.
- REQ-011 SHALL have port hmaster, output, MW: index of the granted master; 0 when none.
- REQ-012 SHALL have port hsel, output, 1: equals |hgrant.
- REQ-013 SHALL have port burst_active, output, 1: high while state is BURST.

Function
- REQ-014 SHALL implement three states: IDLE (no owner), OWNED (owner granted, no beat yet), BURST (owner mid-burst).
- REQ-015 Beat-done definition: hready=1 AND htrans is NONSEQ or SEQ.
- REQ-016 Arbitration point: IDLE; OWNED with owner hreq=0; a beat-done that is the last beat; owner htrans=IDLE with hready=1 in BURST (early termination).
- REQ-017 At an arbitration point, the winner SHALL be registered. hgrant and hmaster SHALL change on the next rising edge: one cycle of latency.
- REQ-018 If no hreq is set at an arbitration point, the next state SHALL be IDLE and hgrant SHALL be 0.
- REQ-019 Fixed mode: the lowest asserted index SHALL win.
- REQ-020 Round-robin mode: the search SHALL start at pointer index and wrap modulo MASTER_NUM. On each grant, the pointer SHALL load (winner+1) mod MASTER_NUM.
- REQ-021 The owner SHALL be re-grantable at an arbitration point in fixed mode. In round-robin mode it SHALL win only if no other master requests.
- REQ-022 Beat counter: 4 bits. It SHALL clear on grant, increment on each beat-done, and hold while hready=0.
- REQ-023 The burst length SHALL be latched on the first NONSEQ beat-done: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16, INCR=undefined.
- REQ-024 Last beat: beat-done with count == length-1. For SINGLE, the first beat SHALL be the last beat.
- REQ-025 INCR (undefined length): the burst SHALL end on owner htrans=IDLE with hready=1, or on owner hreq=0 with hready=1.
- REQ-026 The grant SHALL never change while hready=0. Any arbitration point occurring with hready=0 SHALL be deferred until hready=1.
- REQ-027 A 16-beat count SHALL reach 15 on its last beat without wrapping before release.
- REQ-028 A NONSEQ arriving in BURST before the last beat SHALL be treated as early termination plus a new burst by the same owner: the counter restarts at 1 and the length is re-latched.
- REQ-029 BUSY SHALL neither advance the counter nor release the grant.
- REQ-030 hgrant SHALL be one-hot or zero in every cycle.

Reset
- REQ-031 On hreset_n low, the block SHALL asynchronously force: state IDLE, hgrant 0, hmaster 0, hsel 0, burst_active 0, counter 0, length SINGLE, RR pointer 0.
- REQ-032 Reset deasserted mid-burst SHALL resume from IDLE. Arbitration SHALL occur on the first clock edge after deassertion.

Verification
- REQ-033 Fixed mode, hreq=4'b1010 from IDLE -> hgrant=4'b0010 and hmaster=1 on the next edge.
- REQ-034 Fixed mode, owner master 1 runs INCR4 with hready=1 and hreq=4'b0011 throughout -> hgrant holds 4'b0010 through beat 4. After the 4th beat-done, the next edge gives hgrant=4'b0001.
- REQ-035 Round-robin mode, all four hreq held high with SINGLE transfers -> grant order 0,1,2,3,0.
- REQ-036 INCR8 with hready=0 for 3 cycles at beat 8 -> grant is held. Release occurs one edge after hready=1 completes beat 8.
- REQ-037 INCR16 terminated early by htrans=IDLE at beat 5 -> next owner is granted on the following edge. burst_active falls to 0.
- REQ-038 hreset_n asserted mid-WRAP8 beat 3 -> all outputs are 0 immediately. After release with hreq=4'b0100, hgrant=4'b0100 on the first edge.
